// File: rtl/pipe_tx_arbiter.sv
// Packet-atomic arbiter sharing the PIPE TX datapath between the LTSSM ordered-set
// generator, the data-link packet stream and a periodic SKP ordered-set scheduler.
module pipe_tx_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 4
) (
  input  logic                pclk,
  input  logic                reset_n,
  input  logic [2:0]          generation,
  input  logic                os_req,
  input  logic [DATA_W-1:0]   os_data,
  input  logic [DATA_W/8-1:0] os_k,
  input  logic                os_last,
  output logic                os_ready,
  input  logic                dl_valid,
  input  logic [DATA_W-1:0]   dl_data,
  input  logic [DATA_W/8-1:0] dl_k,
  input  logic                dl_last,
  output logic                dl_ready,
  output logic [DATA_W-1:0]   arbDataOut,
  output logic [DATA_W/8-1:0] arbDataK,
  output logic                arbDataValid,
  output logic                skp_active
);

  localparam int unsigned KW = DATA_W / 8;
  localparam logic [15:0] SkpCntMax = 16'(SKP_INTERVAL - 1);
  localparam logic [3:0]  SkpLast   = 4'(SKP_LEN - 1);

  typedef enum logic [1:0] {StIdle, StOs, StDl, StSkp} state_e;

  state_e            state_q, state_d;
  logic [15:0]       skp_cnt_q, skp_cnt_d;
  logic              skp_pending_q, skp_pending_d;
  logic [3:0]        skp_words_q, skp_words_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KW-1:0]     k_q, k_d;
  logic              valid_q, valid_d;
  logic              skp_active_q, skp_active_d;

  logic              gen_valid;
  logic              gen_8b10b;
  logic [DATA_W-1:0] skp_word;
  logic [KW-1:0]     skp_k;

  assign gen_valid = (generation >= 3'd1) && (generation <= 3'd5);
  assign gen_8b10b = (generation <= 3'd2);

  // Sampled per word, so a rate change lands on the next SKP word.
  assign skp_word = gen_8b10b ? {KW{8'h1C}} : {KW{8'hAA}};
  assign skp_k    = gen_8b10b ? {KW{1'b1}} : {KW{1'b0}};

  assign os_ready     = gen_valid && (state_q == StOs);
  assign dl_ready     = gen_valid && (state_q == StDl);
  assign arbDataOut   = data_q;
  assign arbDataK     = k_q;
  assign arbDataValid = valid_q;
  assign skp_active   = skp_active_q;

  always_comb begin
    state_d       = state_q;
    skp_cnt_d     = skp_cnt_q;
    skp_pending_d = skp_pending_q;
    skp_words_d   = '0;
    data_d        = data_q;
    k_d           = k_q;
    valid_d       = 1'b0;
    skp_active_d  = 1'b0;

    if (!gen_valid) begin
      state_d       = StIdle;
      skp_cnt_d     = '0;
      skp_pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (skp_pending_q) begin
            state_d = StSkp;
          end else if (os_req) begin
            state_d = StOs;
          end else if (dl_valid) begin
            state_d = StDl;
          end
        end
        StOs: begin
          if (os_req) begin
            data_d  = os_data;
            k_d     = os_k;
            valid_d = 1'b1;
            if (os_last) state_d = StIdle;
          end
        end
        StDl: begin
          if (dl_valid) begin
            data_d  = dl_data;
            k_d     = dl_k;
            valid_d = 1'b1;
            if (dl_last) state_d = StIdle;
          end
        end
        StSkp: begin
          data_d       = skp_word;
          k_d          = skp_k;
          valid_d      = 1'b1;
          skp_active_d = 1'b1;
          if (skp_words_q == SkpLast) begin
            state_d = StIdle;
          end else begin
            skp_words_d = skp_words_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase

      // Scheduler restarts on SKP entry and is frozen while SKP words go out.
      if ((state_q == StIdle) && (state_d == StSkp)) begin
        skp_cnt_d     = '0;
        skp_pending_d = 1'b0;
      end else if (state_q != StSkp) begin
        if (skp_cnt_q != SkpCntMax) skp_cnt_d = skp_cnt_q + 16'd1;
        if (skp_cnt_d == SkpCntMax) skp_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
      skp_words_q   <= '0;
      data_q        <= '0;
      k_q           <= '0;
      valid_q       <= 1'b0;
      skp_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      skp_words_q   <= skp_words_d;
      data_q        <= data_d;
      k_q           <= k_d;
      valid_q       <= valid_d;
      skp_active_q  <= skp_active_d;
    end
  end

endmodule

// File: tb/tb_pipe_tx_arbiter.sv
// Directed bench for pipe_tx_arbiter: reset, contention, SKP insertion at Gen2/Gen3,
// source stall, invalid generation and mid-packet reset.
module tb_pipe_tx_arbiter;

  localparam int unsigned DataW = 32;
  localparam int unsigned Kw    = DataW / 8;

  localparam logic [63:0] SIdle = 64'd0;
  localparam logic [63:0] SOs   = 64'd1;
  localparam logic [63:0] SDl   = 64'd2;
  localparam logic [63:0] SSkp  = 64'd3;

  logic             pclk;
  logic             reset_n;
  logic [2:0]       generation;
  logic             os_req;
  logic [DataW-1:0] os_data;
  logic [Kw-1:0]    os_k;
  logic             os_last;
  logic             os_ready;
  logic             dl_valid;
  logic [DataW-1:0] dl_data;
  logic [Kw-1:0]    dl_k;
  logic             dl_last;
  logic             dl_ready;
  logic [DataW-1:0] arbDataOut;
  logic [Kw-1:0]    arbDataK;
  logic             arbDataValid;
  logic             skp_active;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  pipe_tx_arbiter #(
    .DATA_W      (DataW),
    .SKP_INTERVAL(16),
    .SKP_LEN     (4)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .generation  (generation),
    .os_req      (os_req),
    .os_data     (os_data),
    .os_k        (os_k),
    .os_last     (os_last),
    .os_ready    (os_ready),
    .dl_valid    (dl_valid),
    .dl_data     (dl_data),
    .dl_k        (dl_k),
    .dl_last     (dl_last),
    .dl_ready    (dl_ready),
    .arbDataOut  (arbDataOut),
    .arbDataK    (arbDataK),
    .arbDataValid(arbDataValid),
    .skp_active  (skp_active)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Invalid generation parks the DUT in IDLE with the SKP scheduler cleared.
  task automatic clean();
    generation = 3'd0;
    os_req     = 1'b0;
    os_last    = 1'b0;
    dl_valid   = 1'b0;
    dl_last    = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int unsigned idx;
    logic        acc;

    reset_n    = 1'b0;
    generation = 3'd1;
    os_req     = 1'b1;
    os_data    = '0;
    os_k       = '0;
    os_last    = 1'b0;
    dl_valid   = 1'b1;
    dl_data    = '0;
    dl_k       = '0;
    dl_last    = 1'b0;

    // Reset held for three edges with both sources requesting.
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_data", 64'(arbDataOut), 64'h0);
    check_eq("rst_k", 64'(arbDataK), 64'h0);
    check_eq("rst_valid", 64'(arbDataValid), 64'h0);
    check_eq("rst_skp", 64'(skp_active), 64'h0);
    check_eq("rst_os_ready", 64'(os_ready), 64'h0);
    check_eq("rst_dl_ready", 64'(dl_ready), 64'h0);
    reset_n = 1'b1;
    #1;
    check_eq("rel_os_ready0", 64'(os_ready), 64'h0);
    tick();
    check_eq("rel_os_ready1", 64'(os_ready), 64'h1);
    check_eq("rel_dl_ready", 64'(dl_ready), 64'h0);

    // OS vs DL contention, Gen1.
    clean();
    generation = 3'd1;
    os_req     = 1'b1;
    dl_valid   = 1'b1;
    os_data    = 32'h11111111;
    os_k       = 4'h1;
    dl_data    = 32'hDEADBEEF;
    #1;
    check_eq("ct_idle_ready", 64'(os_ready), 64'h0);
    tick();
    check_eq("ct_os_ready", 64'(os_ready), 64'h1);
    check_eq("ct_dl_ready", 64'(dl_ready), 64'h0);
    tick();
    os_data = 32'h22222222;
    os_k    = 4'h0;
    check_eq("ct_w0", 64'(arbDataOut), 64'h11111111);
    check_eq("ct_w0_k", 64'(arbDataK), 64'h1);
    check_eq("ct_w0_v", 64'(arbDataValid), 64'h1);
    tick();
    os_data = 32'h33333333;
    os_last = 1'b1;
    check_eq("ct_w1", 64'(arbDataOut), 64'h22222222);
    check_eq("ct_w1_k", 64'(arbDataK), 64'h0);
    tick();
    os_req  = 1'b0;
    os_last = 1'b0;
    #1;
    check_eq("ct_w2", 64'(arbDataOut), 64'h33333333);
    check_eq("ct_w2_v", 64'(arbDataValid), 64'h1);
    check_eq("ct_bubble_state", 64'(dut.state_q), SIdle);
    check_eq("ct_bubble_dl_ready", 64'(dl_ready), 64'h0);
    tick();
    check_eq("ct_dl_ready", 64'(dl_ready), 64'h1);
    check_eq("ct_os_ready_off", 64'(os_ready), 64'h0);
    check_eq("ct_dl_valid_out", 64'(arbDataValid), 64'h0);

    // Gen2 SKP insertion between continuous 8-word DL packets.
    clean();
    generation = 3'd2;
    idx        = 0;
    dl_valid   = 1'b1;
    dl_k       = '0;
    dl_data    = 32'hD0000000;
    dl_last    = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      acc = dl_ready;
      tick();
      if (acc) idx++;
      dl_data = 32'hD0000000 + idx;
      dl_last = (idx % 8) == 7;
      #1;
      if (c == 9) check_eq("g2_w7", 64'(arbDataOut), 64'hD0000007);
      if (c == 10) check_eq("g2_gap_v", 64'(arbDataValid), 64'h0);
      if (c == 14) check_eq("g2_pend14", 64'(dut.skp_pending_q), 64'h0);
      if (c == 15) check_eq("g2_pend15", 64'(dut.skp_pending_q), 64'h1);
      if (c == 18) check_eq("g2_w15", 64'(arbDataOut), 64'hD000000F);
      if (c == 19) begin
        check_eq("g2_skp_state", 64'(dut.state_q), SSkp);
        check_eq("g2_skp_v0", 64'(arbDataValid), 64'h0);
        check_eq("g2_skp_ready", 64'(dl_ready), 64'h0);
      end
      if (c >= 20 && c <= 23) begin
        check_eq("g2_skp_data", 64'(arbDataOut), 64'h1C1C1C1C);
        check_eq("g2_skp_k", 64'(arbDataK), 64'hF);
        check_eq("g2_skp_act", 64'(skp_active), 64'h1);
        check_eq("g2_skp_v", 64'(arbDataValid), 64'h1);
      end
      if (c == 24) begin
        check_eq("g2_post_act", 64'(skp_active), 64'h0);
        check_eq("g2_post_v", 64'(arbDataValid), 64'h0);
      end
      if (c == 25) begin
        check_eq("g2_resume", 64'(arbDataOut), 64'hD0000010);
        check_eq("g2_resume_v", 64'(arbDataValid), 64'h1);
      end
    end

    // Gen3 SKP wins over a pending OS request.
    clean();
    generation = 3'd3;
    os_data    = 32'h44444444;
    os_k       = 4'h0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 15) begin
        os_req  = 1'b1;
        os_last = 1'b1;
      end
      #1;
      if (c == 15) check_eq("g3_pend_os_ready", 64'(os_ready), 64'h0);
      if (c == 16) begin
        check_eq("g3_skp_state", 64'(dut.state_q), SSkp);
        check_eq("g3_skp_os_ready", 64'(os_ready), 64'h0);
      end
      if (c >= 17 && c <= 20) begin
        check_eq("g3_skp_data", 64'(arbDataOut), 64'hAAAAAAAA);
        check_eq("g3_skp_k", 64'(arbDataK), 64'h0);
        check_eq("g3_skp_act", 64'(skp_active), 64'h1);
      end
      if (c == 21) begin
        check_eq("g3_os_ready", 64'(os_ready), 64'h1);
        check_eq("g3_os_gap_v", 64'(arbDataValid), 64'h0);
      end
      if (c == 22) begin
        check_eq("g3_os_word", 64'(arbDataOut), 64'h44444444);
        check_eq("g3_os_act", 64'(skp_active), 64'h0);
      end
    end

    // DL stall for two cycles mid-packet.
    clean();
    generation = 3'd1;
    dl_valid   = 1'b1;
    dl_data    = 32'h000000A0;
    dl_last    = 1'b0;
    tick();
    tick();
    dl_data = 32'h000000A1;
    check_eq("st_w0", 64'(arbDataOut), 64'hA0);
    tick();
    dl_valid = 1'b0;
    check_eq("st_w1", 64'(arbDataOut), 64'hA1);
    tick();
    check_eq("st_gap1_v", 64'(arbDataValid), 64'h0);
    check_eq("st_gap1_hold", 64'(arbDataOut), 64'hA1);
    check_eq("st_gap1_state", 64'(dut.state_q), SDl);
    tick();
    dl_valid = 1'b1;
    dl_data  = 32'h000000A2;
    dl_last  = 1'b1;
    check_eq("st_gap2_v", 64'(arbDataValid), 64'h0);
    check_eq("st_gap2_state", 64'(dut.state_q), SDl);
    tick();
    dl_valid = 1'b0;
    dl_last  = 1'b0;
    check_eq("st_w2", 64'(arbDataOut), 64'hA2);
    check_eq("st_w2_v", 64'(arbDataValid), 64'h1);
    check_eq("st_end_state", 64'(dut.state_q), SIdle);

    // Invalid generation mid-DL packet.
    clean();
    generation = 3'd1;
    dl_valid   = 1'b1;
    dl_data    = 32'h000000B0;
    tick();
    tick();
    generation = 3'd0;
    #1;
    check_eq("ig_ready_drop", 64'(dl_ready), 64'h0);
    tick();
    check_eq("ig_state", 64'(dut.state_q), SIdle);
    check_eq("ig_dl_ready", 64'(dl_ready), 64'h0);
    check_eq("ig_valid", 64'(arbDataValid), 64'h0);
    check_eq("ig_cnt", 64'(dut.skp_cnt_q), 64'h0);

    // Reset mid-OS packet.
    dl_valid   = 1'b0;
    generation = 3'd1;
    os_req     = 1'b1;
    os_last    = 1'b0;
    os_data    = 32'h000000C0;
    os_k       = 4'h3;
    tick();
    tick();
    check_eq("mr_w0", 64'(arbDataOut), 64'hC0);
    reset_n = 1'b0;
    tick();
    check_eq("mr_state", 64'(dut.state_q), SIdle);
    check_eq("mr_data", 64'(arbDataOut), 64'h0);
    check_eq("mr_k", 64'(arbDataK), 64'h0);
    check_eq("mr_valid", 64'(arbDataValid), 64'h0);
    check_eq("mr_os_ready", 64'(os_ready), 64'h0);
    check_eq("mr_cnt", 64'(dut.skp_cnt_q), 64'h0);
    reset_n = 1'b1;
    os_req  = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
